int_tx_arbiter: RTL and testbench

- Shares one int_sender (32-bit word UART transmitter) between NUM_REQ requesters.
- Per-requester req/ack/done handshake; round-robin arbitration.
- Latches the winner's word, pulses the sender's int_send, then tracks int_ready through busy and back to idle before granting again.
- Sits between the application logic (e.g. echo path, status reporters) and the single int_sender driving tx.

---
 rtl/int_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_int_tx_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_tx_arbiter.sv
// int_tx_arbiter: shares one 32-bit word transmitter (int_sender) between
// NUM_REQ requesters using a req/ack/done handshake and round-robin arbitration.
// Optional build macro INT_TX_ARB_FIXED_PRIO_EN selects fixed priority instead:
// the lowest requester index always wins and the rr pointer stays at 0.
// A grant is made only while the sender reports ready. The winner's word is
// latched, the sender is strobed once, and the arbiter then follows snd_ready
// through busy and back to idle before granting again.
module int_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GW           = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      ack,
  output logic [NUM_REQ-1:0]      done,
  output logic                    busy,
  output logic [GW-1:0]           grant_id,
  output logic [31:0]             snd_data,
  output logic                    snd_send,
  input  logic                    snd_ready
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        rr_q, rr_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [31:0]          data_q, data_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [7:0]           cnt_q, cnt_d;

  // Arbitration results (combinational)
  logic                 found;
  logic [GW-1:0]        winner;
  logic [GW:0]          idx_w;

  // Search for the first pending request starting at the rr pointer, wrapping
  always_comb begin
    found  = 1'b0;
    winner = rr_q;
    idx_w  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_w = {1'b0, rr_q} + (GW+1)'(k);
      if (idx_w >= (GW+1)'(NUM_REQ)) begin
        idx_w = idx_w - (GW+1)'(NUM_REQ);
      end
      if (!found && req[idx_w[GW-1:0]]) begin
        found  = 1'b1;
        winner = idx_w[GW-1:0];
      end
    end
  end

  // State and datapath registers; reset aborts any transfer in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      data_q  <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: grant in IDLE, strobe, wait for busy, wait for idle
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    data_d  = data_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // No grant while the sender is still finishing a previous word
        if (snd_ready && found) begin
          data_d  = req_data[32*int'(winner) +: 32];
          grant_d = winner;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // Give up waiting for busy if the sender finished instantly or ignored the strobe
        if (!snd_ready || cnt_q == 8'(BUSY_TIMEOUT-1)) begin
          state_d = S_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT_DONE: begin
        if (snd_ready) begin
          done_d[grant_q] = 1'b1;
`ifdef INT_TX_ARB_FIXED_PRIO_EN
          rr_d = '0;
`else
          rr_d = (grant_q == GW'(NUM_REQ-1)) ? '0 : grant_q + GW'(1);
`endif
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state so reset clears them at once
  always_comb begin
    ack = '0;
    if (state_q == S_SEND) begin
      ack[grant_q] = 1'b1;
    end
    snd_send = (state_q == S_SEND);
    busy     = (state_q != S_IDLE);
    done     = done_q;
    grant_id = grant_q;
    snd_data = data_q;
  end

endmodule

// File: tb/tb_int_tx_arbiter.sv
// Testbench for int_tx_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
// Build with INT_TX_ARB_FIXED_PRIO_EN defined to exercise fixed priority.
`timescale 1ns/1ps
module tb_int_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;
`ifdef INT_TX_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [32*N-1:0]   req_data;
  logic [N-1:0]      ack, done;
  logic              busy;
  logic [1:0]        grant_id;
  logic [31:0]       snd_data;
  logic              snd_send;
  logic              snd_ready;

  int_tx_arbiter #(.NUM_REQ(N), .GW(2), .BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .ack(ack), .done(done), .busy(busy), .grant_id(grant_id),
    .snd_data(snd_data), .snd_send(snd_send), .snd_ready(snd_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Requester population
  bit          pend [N];
  logic [31:0] word [N];
  bit          auto_mode = 0;
  bit          keep_all  = 0;
  int          ack_cnt [N];
  int          done_cnt [N];

  // Sender behaviour
  bit s_ready = 1;
  int busy_left = 0;
  int busy_len_cfg = 0;
  bit ign_strobe = 0;
  bit hold_low = 0;

  // Reference model: transaction in flight, wait progress, pointer, next-cycle expectations
  bit          m_inflight;
  bit          m_fall;
  int          m_send_cyc;
  int          m_rr;
  int          m_gid;
  logic [31:0] m_data;
  bit          exp_send;
  int          exp_win;
  bit          exp_done;
  int          exp_done_id;

  // Observation logs
  int          send_log[$];
  logic [31:0] data_log[$];
  int          send_cyc, done_cyc, rise_cyc, req_cyc;
  logic [N-1:0] last_done_vec;
  bit          saw_done;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic int log_at(input int i);
    return (i < send_log.size()) ? send_log[i] : -1;
  endfunction

  function automatic logic [31:0] dlog_at(input int i);
    return (i < data_log.size()) ? data_log[i] : 32'hdead_beef;
  endfunction

  task automatic model_reset();
    m_inflight = 0; m_fall = 0; m_rr = 0; m_gid = 0; m_data = '0;
    exp_send = 0; exp_done = 0; exp_win = 0; exp_done_id = 0; m_send_cyc = 0;
  endtask

  // One clock cycle, called just after the falling edge
  task automatic step();
    logic [N-1:0] e_ack, e_done;
    bit nsend, ndone;
    int nwin, nid;
    cyc++;
    e_ack = '0;  if (exp_send) e_ack[exp_win] = 1'b1;
    e_done = '0; if (exp_done) e_done[exp_done_id] = 1'b1;
    chk("snd_send", snd_send, exp_send);
    chk("ack", ack, e_ack);
    chk("done", done, e_done);
    chk("busy", busy, m_inflight);
    chk("grant_id", grant_id, m_gid);
    chk("snd_data", snd_data, m_data);
    if (exp_send) m_send_cyc = cyc;
    if (snd_send) begin
      send_log.push_back(int'(grant_id));
      data_log.push_back(snd_data);
      send_cyc = cyc;
    end
    if (done != '0) begin
      done_cyc = cyc; last_done_vec = done; saw_done = 1;
    end
    for (int i = 0; i < N; i++) begin
      if (ack[i]) ack_cnt[i]++;
      if (done[i]) done_cnt[i]++;
    end
    // Requesters react to what they saw this cycle
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        if (keep_all || (auto_mode && $urandom_range(3) == 0)) begin
          if (auto_mode) word[i] = $urandom;
        end else begin
          pend[i] = 0;
        end
      end else if (auto_mode) begin
        if (!pend[i] && $urandom_range(7) == 0) begin
          pend[i] = 1; word[i] = $urandom;
        end else if (pend[i] && $urandom_range(63) == 0) begin
          pend[i] = 0;
        end
      end
      req[i] = pend[i];
      req_data[32*i +: 32] = word[i];
    end
    // Sender: goes busy for a while after a strobe unless it ignores it
    if (snd_send && !(ign_strobe || (auto_mode && $urandom_range(7) == 0))) begin
      s_ready = 0;
      busy_left = (busy_len_cfg > 0) ? busy_len_cfg : int'($urandom_range(1, 8));
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        s_ready = 1; rise_cyc = cyc;
      end
    end
    snd_ready = s_ready && !hold_low;
    // Predict the next cycle from the inputs the coming rising edge will see
    nsend = 0; ndone = 0; nwin = 0; nid = 0;
    if (rst) begin
      if (!m_inflight) begin
        if (snd_ready && req != '0) begin
          nsend = 1; nwin = pick(req, m_rr);
          m_gid = nwin; m_data = word[nwin];
          m_inflight = 1; m_fall = 0;
        end
      end else if (!exp_send) begin
        if (!m_fall) begin
          if (!snd_ready || (cyc - m_send_cyc) == TO) m_fall = 1;
        end else if (snd_ready) begin
          ndone = 1; nid = m_gid; m_inflight = 0;
          m_rr = FIXED ? 0 : (m_gid + 1) % N;
        end
      end
    end
    exp_send = nsend; exp_win = nwin; exp_done = ndone; exp_done_id = nid;
  endtask

  // Assert reset mid-cycle, confirm outputs clear immediately, release on a falling edge
  task automatic do_reset();
    #2; rst = 1'b0; #1;
    chk("rst_out", {ack, done, busy, grant_id, snd_data, snd_send}, 64'd0);
    model_reset();
    @(negedge clk); step();
    @(negedge clk); step();
    @(negedge clk); rst = 1'b1; step();
  endtask

  task automatic run_until_done(input string tag, input int bound);
    saw_done = 0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk); step();
      if (saw_done) break;
    end
    chk({tag, "_done_seen"}, saw_done, 1'b1);
  endtask

  task automatic run_until_wait_done(input string tag, input int bound);
    bit hit;
    hit = 0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk); step();
      if (m_inflight && m_fall) begin hit = 1; break; end
    end
    chk({tag, "_wait_done_reached"}, hit, 1'b1);
  endtask

  initial begin
    int d0, a2, d2;
    rst = 1'b0; req = '0; req_data = '0; snd_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; word[i] = '0; ack_cnt[i] = 0; done_cnt[i] = 0;
    end
    send_cyc = 0; done_cyc = 0; rise_cyc = 0; req_cyc = 0; last_done_vec = '0; saw_done = 0;
    model_reset();
    @(negedge clk); do_reset();

    // All four requesting continuously, words 0..3
    keep_all = 1; busy_len_cfg = 3;
    for (int i = 0; i < N; i++) begin pend[i] = 1; word[i] = 32'(i); end
    send_log.delete(); data_log.delete();
    for (int k = 0; k < 300 && send_log.size() < 5; k++) begin
      @(negedge clk); step();
    end
    chk("order_count", send_log.size() >= 5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("order_grant", log_at(i), FIXED ? 0 : i % N);
      chk("order_word", dlog_at(i), FIXED ? 32'd0 : 32'(i % N));
    end
    keep_all = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    repeat (40) begin @(negedge clk); step(); end

    // Single request from requester 1 with a slow sender
    busy_len_cfg = 40;
    pend[1] = 1; word[1] = 32'h41424344;
    send_log.delete(); data_log.delete();
    @(negedge clk); step(); req_cyc = cyc;
    run_until_done("single", 120);
    chk("single_sends", send_log.size(), 1);
    chk("single_gid", log_at(0), 1);
    chk("single_word", dlog_at(0), 32'h41424344);
    // req is seen in the IDLE cycle it is driven; the strobe follows in the next (SEND) cycle
    chk("single_latency", send_cyc - req_cyc, 1);
    chk("single_done_after_ready", done_cyc - rise_cyc, 1);
    chk("single_done_id", last_done_vec, 4'b0010);
    repeat (3) begin @(negedge clk); step(); end

    // Sender not ready when the request arrives
    busy_len_cfg = 5; hold_low = 1;
    pend[0] = 1; word[0] = $urandom;
    send_log.delete(); data_log.delete();
    repeat (10) begin @(negedge clk); step(); end
    chk("notready_no_send", send_log.size(), 0);
    hold_low = 0;
    run_until_done("notready", 60);
    chk("notready_sends", send_log.size(), 1);
    chk("notready_gid", log_at(0), 0);

    // Sender ignores the strobe: busy wait times out
    ign_strobe = 1;
    pend[0] = 1; word[0] = $urandom;
    run_until_done("timeout", 80);
    chk("timeout_span", done_cyc - send_cyc, TO + 2);
    chk("timeout_done_id", last_done_vec, 4'b0001);
    chk("timeout_idle", busy, 1'b0);
    ign_strobe = 0;
    repeat (3) begin @(negedge clk); step(); end

    // Reset while waiting for the sender to finish
    busy_len_cfg = 20;
    pend[0] = 1; word[0] = $urandom;
    run_until_wait_done("reset", 40);
    @(negedge clk); step();
    d0 = done_cnt[0];
    pend[3] = 1; word[3] = 32'hCAFE0003;
    send_log.delete(); data_log.delete();
    do_reset();
    run_until_done("reset", 80);
    chk("reset_no_done0", done_cnt[0] - d0, 0);
    chk("reset_gid", log_at(0), 3);
    chk("reset_word", dlog_at(0), 32'hCAFE0003);
    repeat (3) begin @(negedge clk); step(); end

    // Requester 2 withdraws while requester 0 is being served
    busy_len_cfg = 10;
    pend[0] = 1; word[0] = $urandom;
    run_until_wait_done("withdraw", 40);
    a2 = ack_cnt[2]; d2 = done_cnt[2];
    pend[2] = 1; word[2] = $urandom;
    @(negedge clk); step();
    pend[2] = 0;
    run_until_done("withdraw", 60);
    repeat (5) begin @(negedge clk); step(); end
    chk("withdraw_no_ack2", ack_cnt[2] - a2, 0);
    chk("withdraw_no_done2", done_cnt[2] - d2, 0);
    chk("withdraw_idle", busy, 1'b0);

    // Randomized traffic
    busy_len_cfg = 0; auto_mode = 1;
    repeat (3000) begin @(negedge clk); step(); end
    auto_mode = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    repeat (100) begin @(negedge clk); step(); end
    chk("final_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
